// File: rtl/stack_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : stack_operand_sequencer_if
// Brief    : Sample-triple intake and stack operand/result bus for the
//            echo-canceller operand sequencer.
// Revision : 1.0
// ============================================================================
interface stack_operand_sequencer_if #(
    parameter int W = 16
);
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sig0;
    logic [W-1:0] sig1;
    logic [W-1:0] sig2;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         mod;
    logic         enable;
    logic [W-1:0] fb_in;
    logic         fb_valid;
    logic         done;
    logic         err;

    // Upstream/stack side: supplies samples and results, observes operands.
    modport master (
        output clear, in_valid, sig0, sig1, sig2, fb_in, fb_valid,
        input  in_ready, a, b, c, mod, enable, done, err
    );

    // Sequencer side.
    modport slave (
        input  clear, in_valid, sig0, sig1, sig2, fb_in, fb_valid,
        output in_ready, a, b, c, mod, enable, done, err
    );
endinterface
`default_nettype wire

// File: rtl/stack_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_operand_sequencer
// Brief    : Presents a sample triple to the stack/MAC in two operand phases,
//            folds the stack result into the accumulator, guards with watchdog.
// Revision : 1.0
// ============================================================================
module stack_operand_sequencer #(
    parameter int W       = 16,
    parameter int TIMEOUT = 15
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    stack_operand_sequencer_if.slave  bus
);

    localparam int c_WDOG_W = $clog2(TIMEOUT + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PH0  = 2'd1,
        S_PH1  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t              r_state;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_c;
    logic                r_mod;
    logic                r_enable;
    logic                r_done;
    logic                r_err;
    logic [W-1:0]        r_acc;
    logic [W-1:0]        r_fb;
    logic [W-1:0]        r_s0;
    logic [W-1:0]        r_s1;
    logic [W-1:0]        r_s2;
    logic [c_WDOG_W-1:0] r_wdog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_mod    <= 1'b0;
            r_enable <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_acc    <= '0;
            r_fb     <= '0;
            r_s0     <= '0;
            r_s1     <= '0;
            r_s2     <= '0;
            r_wdog   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // clear takes priority and blocks acceptance for this cycle
                    if (bus.clear) begin
                        r_acc    <= '0;
                        r_fb     <= '0;
                        r_err    <= 1'b0;
                        r_enable <= 1'b0;
                    end else if (bus.in_valid) begin
                        r_s0     <= bus.sig0;
                        r_s1     <= bus.sig1;
                        r_s2     <= bus.sig2;
                        r_a      <= bus.sig0;
                        r_b      <= bus.sig1;
                        r_c      <= r_acc;
                        r_mod    <= 1'b0;
                        r_enable <= 1'b1;
                        r_state  <= S_PH0;
                    end else begin
                        r_enable <= 1'b0;
                    end
                end
                S_PH0: begin
                    r_a      <= r_s2;
                    r_b      <= r_acc;
                    r_c      <= r_fb;
                    r_mod    <= 1'b1;
                    r_enable <= 1'b1;
                    r_state  <= S_PH1;
                end
                S_PH1: begin
                    r_enable <= 1'b0;
                    r_wdog   <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the expiry cycle still wins
                    if (bus.fb_valid) begin
                        r_acc   <= bus.fb_in;
                        r_fb    <= bus.fb_in;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_wdog == c_WDOG_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog  <= r_wdog + 1'b1;
                    end
                end
                default: begin
                    r_enable <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = (r_state == S_IDLE);
    assign bus.a        = r_a;
    assign bus.b        = r_b;
    assign bus.c        = r_c;
    assign bus.mod      = r_mod;
    assign bus.enable   = r_enable;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_stack_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_operand_sequencer
// Brief    : Self-checking bench: fixed vector table, corner sequences and
//            randomized transactions against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_stack_operand_sequencer;

    localparam int W  = 16;
    localparam int TO = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    stack_operand_sequencer_if #(.W(W)) bus();

    stack_operand_sequencer #(.W(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level model state
    logic [W-1:0] acc_m;
    logic [W-1:0] fb_m;
    logic         err_m;

    typedef struct {
        logic [W-1:0] x0, x1, x2;
        int           d;
        logic [W-1:0] fbv;
        logic [W-1:0] c0, b1, c1;
        logic         done_e, err_e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // d = cycle (1-based) after WAIT_FB entry on which fb_valid is driven; d>TO means never
    task automatic run_txn(input logic [W-1:0] x0, x1, x2, input int d, input logic [W-1:0] fbv,
                           input bit hold, input bit fbph0,
                           input logic [W-1:0] c0, b1, c1, input logic done_e, err_e);
        int  n;
        int  k;
        bit  fin;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before", {31'd0, bus.in_ready}, 32'd1);
        bus.sig0 = x0; bus.sig1 = x1; bus.sig2 = x2;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("ph0_a", bus.a, x0);
        chk("ph0_b", bus.b, x1);
        chk("ph0_c", bus.c, c0);
        chk("ph0_mod", bus.mod, 0);
        chk("ph0_en", bus.enable, 1);
        chk("ph0_ready", bus.in_ready, 0);
        if (hold) begin
            bus.sig0 = ~x0; bus.sig1 = ~x1; bus.sig2 = ~x2;
        end else begin
            bus.in_valid = 1'b0;
        end
        if (fbph0) begin
            bus.fb_valid = 1'b1;
            bus.fb_in    = 16'hBEEF;
        end
        @(negedge clk);
        bus.fb_valid = 1'b0;
        chk("ph1_a", bus.a, x2);
        chk("ph1_b", bus.b, b1);
        chk("ph1_c", bus.c, c1);
        chk("ph1_mod", bus.mod, 1);
        chk("ph1_en", bus.enable, 1);
        @(negedge clk);
        chk("wait_en", bus.enable, 0);
        chk("wait_a_hold", bus.a, x2);
        chk("wait_mod_hold", bus.mod, 1);
        chk("wait_ready", bus.in_ready, 0);
        k   = 0;
        fin = 1'b0;
        while (!fin) begin
            k++;
            if (k == d) begin
                bus.fb_valid = 1'b1;
                bus.fb_in    = fbv;
            end
            @(negedge clk);
            bus.fb_valid = 1'b0;
            fin = (k >= d) || (k >= TO);
            if (!fin) begin
                chk("wait_ready_k", bus.in_ready, 0);
                chk("wait_done_k", bus.done, 0);
            end
        end
        bus.in_valid = 1'b0;
        chk("end_ready", bus.in_ready, 1);
        chk("end_done", bus.done, done_e);
        chk("end_err", bus.err, err_e);
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
        chk("idle_en", bus.enable, 0);
        // model update
        if (d <= TO) begin
            acc_m = fbv;
            fb_m  = fbv;
        end else begin
            err_m = 1'b1;
        end
    endtask

    task automatic model_txn(input logic [W-1:0] x0, x1, x2, input int d,
                             input logic [W-1:0] fbv, input bit hold, input bit fbph0);
        run_txn(x0, x1, x2, d, fbv, hold, fbph0, acc_m, acc_m, fb_m,
                (d <= TO), err_m | (d > TO));
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{x0:16'd3, x1:16'd5, x2:16'd7, d:2,  fbv:16'h0010,
                   c0:16'h0000, b1:16'h0000, c1:16'h0000, done_e:1'b1, err_e:1'b0};
        tbl[1] = '{x0:16'd1, x1:16'd2, x2:16'd4, d:1,  fbv:16'h1234,
                   c0:16'h0010, b1:16'h0010, c1:16'h0010, done_e:1'b1, err_e:1'b0};
        tbl[2] = '{x0:16'd9, x1:16'd8, x2:16'd7, d:99, fbv:16'hFFFF,
                   c0:16'h1234, b1:16'h1234, c1:16'h1234, done_e:1'b0, err_e:1'b1};
        tbl[3] = '{x0:16'd4, x1:16'd4, x2:16'd4, d:3,  fbv:16'h0055,
                   c0:16'h1234, b1:16'h1234, c1:16'h1234, done_e:1'b1, err_e:1'b1};

        bus.clear = 1'b0; bus.in_valid = 1'b0; bus.fb_valid = 1'b0;
        bus.sig0 = '0; bus.sig1 = '0; bus.sig2 = '0; bus.fb_in = '0;
        acc_m = '0; fb_m = '0; err_m = 1'b0;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_a", bus.a, 0);
        chk("rst_b", bus.b, 0);
        chk("rst_c", bus.c, 0);
        chk("rst_en", bus.enable, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_err", bus.err, 0);
        chk("rst_done", bus.done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i].x0, tbl[i].x1, tbl[i].x2, tbl[i].d, tbl[i].fbv, 1'b0, 1'b0,
                    tbl[i].c0, tbl[i].b1, tbl[i].c1, tbl[i].done_e, tbl[i].err_e);
        end

        // clear in IDLE with in_valid high: no acceptance, err and acc zeroed
        bus.clear = 1'b1; bus.in_valid = 1'b1;
        bus.sig0 = 16'hAAAA; bus.sig1 = 16'hBBBB; bus.sig2 = 16'hCCCC;
        @(negedge clk);
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        chk("clr_ready", bus.in_ready, 1);
        chk("clr_en", bus.enable, 0);
        chk("clr_err", bus.err, 0);
        acc_m = '0; fb_m = '0; err_m = 1'b0;
        run_txn(16'd6, 16'd6, 16'd6, 1, 16'h0077, 1'b0, 1'b0,
                16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
        acc_m = 16'h0077; fb_m = 16'h0077;

        // in_valid held and samples changed during the transaction
        model_txn(16'h0101, 16'h0202, 16'h0303, 2, 16'h0abc, 1'b1, 1'b0);
        // fb_valid in PH0 is ignored
        model_txn(16'h1111, 16'h2222, 16'h3333, 1, 16'h0def, 1'b0, 1'b1);
        model_txn(16'h0001, 16'h0002, 16'h0003, 1, 16'h4444, 1'b0, 1'b0);
        // fb_valid on the expiry cycle wins
        model_txn(16'h0007, 16'h0008, 16'h0009, TO, 16'h5151, 1'b0, 1'b0);
        model_txn(16'h000a, 16'h000b, 16'h000c, 1, 16'h6262, 1'b0, 1'b0);

        // Reset during PH1 discards the transaction and the accumulator
        bus.sig0 = 16'h0e0e; bus.sig1 = 16'h0f0f; bus.sig2 = 16'h0d0d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_mod", bus.mod, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_a", bus.a, 0);
        chk("mrst_b", bus.b, 0);
        chk("mrst_c", bus.c, 0);
        chk("mrst_mod", bus.mod, 0);
        chk("mrst_en", bus.enable, 0);
        chk("mrst_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        acc_m = '0; fb_m = '0; err_m = 1'b0;
        model_txn(16'h1357, 16'h2468, 16'h9abc, 2, 16'h7777, 1'b0, 1'b0);

        // Randomized transactions
        for (int i = 0; i < 25; i++) begin
            model_txn(W'($urandom), W'($urandom), W'($urandom),
                      int'($urandom_range(1, TO + 2)), W'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 5) == 0) begin
                bus.clear = 1'b1;
                @(negedge clk);
                bus.clear = 1'b0;
                chk("rclr_err", bus.err, 0);
                acc_m = '0; fb_m = '0; err_m = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
